spi_ram_master: RTL and testbench

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

---
 rtl/spi_ram_master_if.sv | 29 ++
 rtl/spi_ram_master.sv | 148 ++++++++++++++
 tb/tb_spi_ram_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_master_if.sv
// Request/response bundle between a client and spi_ram_master.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. req_wr/req_addr/req_wdata must be stable while
// req_valid is 1 and are captured only on that edge. rsp_valid is a single-cycle
// pulse with no back-pressure. rsp_rdata keeps the last read byte until the
// next read completes.
interface spi_ram_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  // Client side: offers requests, observes responses.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  // Controller side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master that performs single-byte RAM reads and writes through an SPI
// wrapper. Every operation is two 10-bit frames {cmd[1:0], payload[7:0]},
// sent MSB first, separated by GAP ss_n-high cycles. A read then idles
// RD_LAT cycles and shifts in 8 MISO bits, MSB first.
module spi_ram_master #(
  parameter int unsigned RD_LAT = 2,  // 0..15
  parameter int unsigned GAP    = 1   // 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_master_if.slave  bus,
  output logic             ss_n,
  output logic             MOSI,
  input  logic             MISO,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_SHIFT     = 3'd2,
    S_GAP       = 3'd3,
    S_WAIT_MISO = 3'd4,
    S_CAPTURE   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // Terminal counts of the per-state 4-bit counter.
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);
  localparam logic [3:0] LAT_LAST   = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] CAP_LAST   = 4'd7;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       ready;
  logic       hs;

  // Latched request.
  logic       wr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  // 0 while the first (address) frame is in flight, 1 for the second frame.
  logic       second_q;

  logic [9:0] frame;
  logic [9:0] sh_q;
  logic [7:0] cap_q;
  logic [7:0] rdata_q;

  // Ready is forced low while reset is held even though state is IDLE.
  assign ready = rst_n && (state_q == S_IDLE);
  assign hs    = ready && bus.req_valid;

  // Frame for the current phase: cmd = {read, second}; the read-data frame
  // carries a zero payload.
  assign frame = {~wr_q, second_q, second_q ? (wr_q ? wdata_q : 8'h00) : addr_q};

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (hs) state_d = S_START;
      S_START:     state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          if (!second_q)        state_d = S_GAP;
          else if (wr_q)        state_d = S_DONE;
          else if (RD_LAT == 0) state_d = S_CAPTURE;
          else                  state_d = S_WAIT_MISO;
        end
      end
      S_GAP:       if (cnt_q == GAP_LAST) state_d = S_START;
      S_WAIT_MISO: if (cnt_q == LAT_LAST) state_d = S_CAPTURE;
      S_CAPTURE:   if (cnt_q == CAP_LAST) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: everything is a function of registered state, so reset
  // forces the pins to their idle levels asynchronously.
  always_comb begin
    ss_n          = 1'b1;
    MOSI          = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      S_START, S_WAIT_MISO, S_CAPTURE: ss_n = 1'b0;
      S_SHIFT: begin
        ss_n = 1'b0;
        MOSI = sh_q[9];
      end
      S_DONE:  bus.rsp_valid = 1'b1;
      default: ss_n = 1'b1;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_rdata = rdata_q;
  assign dbg_state     = state_q;

  // State register and per-state counter; the counter restarts at 0 on every
  // state entry and is held at 0 in IDLE so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || (state_q == S_IDLE)) cnt_q <= 4'd0;
      else                                             cnt_q <= cnt_q + 4'd1;
    end
  end

  // Request latch, frame shifter and MISO capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      second_q <= 1'b0;
      sh_q     <= 10'd0;
      cap_q    <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      if (hs) begin
        wr_q     <= bus.req_wr;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        second_q <= 1'b0;
      end
      if ((state_q == S_GAP) && (state_d == S_START)) second_q <= 1'b1;

      // START loads the frame so SHIFT presents bit 9 on its first cycle.
      if (state_q == S_START)      sh_q <= frame;
      else if (state_q == S_SHIFT) sh_q <= {sh_q[8:0], 1'b0};

      // MISO is only looked at in CAPTURE; the final bit goes straight into
      // rsp_rdata so the byte is visible during DONE.
      if (state_q == S_CAPTURE) begin
        cap_q <= {cap_q[6:0], MISO};
        if (cnt_q == CAP_LAST) rdata_q <= {cap_q[6:0], MISO};
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (RD_LAT=2/GAP=1 and RD_LAT=0/GAP=15),
// an SPI RAM wrapper model per instance, and scoreboards for per-cycle pin
// timing, transmitted frames and responses.
module tb_spi_ram_master;

  localparam int LAT0 = 2;
  localparam int GAP0 = 1;
  localparam int LAT1 = 0;
  localparam int GAP1 = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Clock/reset.
  always #5 clk = ~clk;

  spi_ram_master_if bus0 ();
  spi_ram_master_if bus1 ();

  logic [1:0] ss_v;
  logic [1:0] mosi_v;
  logic [1:0] miso_v = 2'b00;
  logic [2:0] dbg0, dbg1;

  spi_ram_master #(.RD_LAT(LAT0), .GAP(GAP0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .ss_n(ss_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0]), .dbg_state(dbg0)
  );

  spi_ram_master #(.RD_LAT(LAT1), .GAP(GAP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .ss_n(ss_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1]), .dbg_state(dbg1)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Scoreboard queues: per-cycle {ss_n, rsp_valid, req_ready, busy}, frames, read data.
  logic [3:0] exp_tim_q0[$];
  logic [3:0] exp_tim_q1[$];
  logic [9:0] exp_fr_q0[$];
  logic [9:0] exp_fr_q1[$];
  logic [7:0] exp_rsp_q0[$];
  logic [7:0] exp_rsp_q1[$];

  task automatic check(string name, int d, logic [15:0] act, logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sig(int d);
    if (d == 0) return {ss_v[0], bus0.rsp_valid, bus0.req_ready, bus0.busy};
    return {ss_v[1], bus1.rsp_valid, bus1.req_ready, bus1.busy};
  endfunction

  function automatic logic get_rdy(int d);
    return (d == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  function automatic logic [7:0] rdata(int d);
    return (d == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
  endfunction

  task automatic drive(int d, logic v, logic wr, logic [7:0] a, logic [7:0] w);
    if (d == 0) begin
      bus0.req_valid = v; bus0.req_wr = wr; bus0.req_addr = a; bus0.req_wdata = w;
    end else begin
      bus1.req_valid = v; bus1.req_wr = wr; bus1.req_addr = a; bus1.req_wdata = w;
    end
  endtask

  // SPI RAM wrapper model + frame/timing/response monitors.
  int         lowcnt [2];
  logic [9:0] sh [2];
  logic [7:0] last_addr [2];
  logic [7:0] rd_byte [2];
  logic [1:0] reading = 2'b00;
  logic [7:0] mem [2][256];
  bit         mem_init = 1'b0;
  int         k, lat;
  logic [9:0] fexp;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[0][i] = 8'h00;
        mem[1][i] = 8'h00;
      end
      mem[0][8'h07] = 8'h5A;
      mem[1][8'hFF] = 8'hE7;
      mem_init = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      // Per-cycle pin timing.
      if (d == 0 && exp_tim_q0.size() > 0) check("cycle_pins", 0, 16'(sig(0)), 16'(exp_tim_q0.pop_front()));
      if (d == 1 && exp_tim_q1.size() > 0) check("cycle_pins", 1, 16'(sig(1)), 16'(exp_tim_q1.pop_front()));

      // Responses.
      if (sig(d)[2]) begin
        if (d == 0) begin
          if (exp_rsp_q0.size() == 0) check("unexpected_rsp", 0, 16'd1, 16'd0);
          else check("rsp_rdata", 0, 16'(rdata(0)), 16'(exp_rsp_q0.pop_front()));
        end else begin
          if (exp_rsp_q1.size() == 0) check("unexpected_rsp", 1, 16'd1, 16'd0);
          else check("rsp_rdata", 1, 16'(rdata(1)), 16'(exp_rsp_q1.pop_front()));
        end
      end

      // Frames and MISO drive.
      lat = (d == 0) ? LAT0 : LAT1;
      if (ss_v[d]) begin
        lowcnt[d] = 0;
        reading[d] = 1'b0;
        miso_v[d] = 1'($urandom_range(0, 1));
      end else begin
        lowcnt[d]++;
        if (lowcnt[d] >= 2 && lowcnt[d] <= 11) sh[d] = {sh[d][8:0], mosi_v[d]};
        else check("mosi_idle", d, 16'(mosi_v[d]), 16'd0);
        if (lowcnt[d] == 11) begin
          if ((d == 0 && exp_fr_q0.size() == 0) || (d == 1 && exp_fr_q1.size() == 0)) begin
            check("unexpected_frame", d, 16'(sh[d]), 16'd0);
          end else begin
            fexp = (d == 0) ? exp_fr_q0.pop_front() : exp_fr_q1.pop_front();
            check("frame", d, 16'(sh[d]), 16'(fexp));
          end
          case (sh[d][9:8])
            2'b00:   last_addr[d] = sh[d][7:0];
            2'b01:   mem[d][last_addr[d]] = sh[d][7:0];
            2'b10:   last_addr[d] = sh[d][7:0];
            default: begin
              rd_byte[d] = mem[d][last_addr[d]];
              reading[d] = 1'b1;
            end
          endcase
        end
        k = lowcnt[d] - 12 - lat;
        if (reading[d] && k >= 0 && k <= 7) miso_v[d] = rd_byte[d][7 - k];
        else miso_v[d] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Driver: waits for ready, pushes expectations, handshakes.
  task automatic run_op(int d, bit wr, logic [7:0] addr, logic [7:0] wdata,
                        logic [7:0] exp_rd, bit keep, bit abort);
    int guard = 0;
    int g, l, done;
    logic s;
    while (!get_rdy(d) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!get_rdy(d)) begin
      check("ready_timeout", d, 16'd0, 16'd1);
      return;
    end
    if (d == 0) exp_fr_q0.push_back({wr ? 2'b00 : 2'b10, addr});
    else        exp_fr_q1.push_back({wr ? 2'b00 : 2'b10, addr});
    if (!abort) begin
      if (d == 0) begin
        exp_fr_q0.push_back({wr ? 2'b01 : 2'b11, wr ? wdata : 8'h00});
        exp_rsp_q0.push_back(exp_rd);
      end else begin
        exp_fr_q1.push_back({wr ? 2'b01 : 2'b11, wr ? wdata : 8'h00});
        exp_rsp_q1.push_back(exp_rd);
      end
    end
    drive(d, 1'b1, wr, addr, wdata);
    @(posedge clk);
    #1;
    // Scrambled fields while busy must be ignored.
    if (keep) drive(d, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    else      drive(d, 1'b0, 1'b0, 8'h00, 8'h00);
    if (!abort) begin
      g    = (d == 0) ? GAP0 : GAP1;
      l    = (d == 0) ? LAT0 : LAT1;
      done = 23 + g + (wr ? 0 : l + 8);
      for (int n = 1; n <= done + 1; n++) begin
        s = !((n <= 11) || (n >= 12 + g && n <= done - 1));
        if (d == 0) exp_tim_q0.push_back({s, n == done, n == done + 1, n <= done});
        else        exp_tim_q1.push_back({s, n == done, n == done + 1, n <= done});
      end
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset values while reset is held.
    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_pins", d, 16'(sig(d)), 16'b1000);
      check("reset_mosi", d, 16'(mosi_v[d]), 16'd0);
      check("reset_rdata", d, 16'(rdata(d)), 16'h00);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check("ready_after_reset", d, 16'(sig(d)), 16'b1010);

    // Instance 0: RD_LAT=2, GAP=1.
    run_op(0, 1'b1, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b0);
    run_op(0, 1'b0, 8'h07, 8'h00, 8'h5A, 1'b0, 1'b0);
    run_op(0, 1'b0, 8'hA5, 8'hFF, 8'h3C, 1'b0, 1'b0);
    // Back-to-back with req_valid held high.
    run_op(0, 1'b1, 8'h10, 8'hC3, 8'h3C, 1'b1, 1'b0);
    run_op(0, 1'b0, 8'h10, 8'h00, 8'hC3, 1'b0, 1'b0);

    // Reset during SHIFT of the second write frame.
    run_op(0, 1'b1, 8'h20, 8'h99, 8'h00, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    check("mid_op_state", 0, 16'(dbg0), 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pins", 0, 16'(sig(0)), 16'b1000);
    check("async_reset_mosi", 0, 16'(mosi_v[0]), 16'd0);
    check("async_reset_rdata", 0, 16'(rdata(0)), 16'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("ready_after_reset2", 0, 16'(sig(0)), 16'b1010);
    run_op(0, 1'b1, 8'h21, 8'h44, 8'h00, 1'b0, 1'b0);
    run_op(0, 1'b0, 8'h21, 8'h00, 8'h44, 1'b0, 1'b0);

    // Instance 1: RD_LAT=0, GAP=15.
    run_op(1, 1'b0, 8'hFF, 8'h00, 8'hE7, 1'b0, 1'b0);
    run_op(1, 1'b1, 8'hFF, 8'h81, 8'hE7, 1'b0, 1'b0);
    run_op(1, 1'b0, 8'hFF, 8'h00, 8'h81, 1'b0, 1'b0);

    // Drain scoreboards with a bounded wait.
    for (int i = 0; i < 300; i++) begin
      if (exp_tim_q0.size() == 0 && exp_tim_q1.size() == 0 && exp_fr_q0.size() == 0 &&
          exp_fr_q1.size() == 0 && exp_rsp_q0.size() == 0 && exp_rsp_q1.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timing", 0, 16'(exp_tim_q0.size() + exp_tim_q1.size()), 16'd0);
    check("drain_frames", 0, 16'(exp_fr_q0.size() + exp_fr_q1.size()), 16'd0);
    check("drain_rsp", 0, 16'(exp_rsp_q0.size() + exp_rsp_q1.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
